// File: rtl/mips_mem_pkg.sv
// Shared definitions for the loadable MIPS program memory.
//   state_e              : loader/fetch FSM state
//   MIPS_NOP             : word returned on a faulted fetch
//   DEFAULT_BASE_ADDRESS : byte address of word 0 (MARS .text base)
package mips_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_e;

    localparam logic [31:0] MIPS_NOP             = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_BASE_ADDRESS = 32'h0040_0000;

endpackage

// File: rtl/program_memory_loadable_if.sv
// Loader and fetch bus of the loadable program memory.
//   master : loader/fetch side (drives load_*, fetch_req, Address)
//   slave  : memory side (drives load_ready/done/count, Instruction, instr_valid, faults)
interface program_memory_loadable_if #(
    parameter int unsigned MEMORY_DEPTH = 64,
    parameter int unsigned DATA_WIDTH   = 32
);

    localparam int unsigned CW = $clog2(MEMORY_DEPTH + 1);

    logic                  load_start;
    logic                  load_valid;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  load_last;
    logic                  load_ready;
    logic                  load_done;
    logic [CW-1:0]         load_count;

    logic                  fetch_req;
    logic [DATA_WIDTH-1:0] Address;
    logic [DATA_WIDTH-1:0] Instruction;
    logic                  instr_valid;
    logic                  fault_misaligned;
    logic                  fault_range;

    modport master (
        output load_start, load_valid, load_data, load_last, fetch_req, Address,
        input  load_ready, load_done, load_count, Instruction, instr_valid,
               fault_misaligned, fault_range
    );

    modport slave (
        input  load_start, load_valid, load_data, load_last, fetch_req, Address,
        output load_ready, load_done, load_count, Instruction, instr_valid,
               fault_misaligned, fault_range
    );

endinterface

// File: rtl/sync_ram_1r1w.sv
// Single-clock RAM: one write port, one registered read port, no array reset.
//   clk      : clock, rising edge
//   we_i     : write enable,  waddr_i / wdata_i : write address / data
//   re_i     : read enable,   raddr_i          : read address
//   rdata_o  : read data, updated one edge after re_i, held otherwise
module sync_ram_1r1w #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned WIDTH = 32,
    parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/program_memory_loadable.sv
// Run-time loadable instruction memory for the MIPS fetch stage.
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   bus   : loader port (load_start/valid/data/last -> load_ready/done/count) and
//           fetch port (fetch_req/Address -> Instruction/instr_valid/fault_*),
//           responses one cycle after the request.
module program_memory_loadable
    import mips_mem_pkg::*;
#(
    parameter int unsigned           MEMORY_DEPTH = 64,
    parameter int unsigned           DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDRESS = DATA_WIDTH'(DEFAULT_BASE_ADDRESS)
) (
    input logic                      clk,
    input logic                      reset,
    program_memory_loadable_if.slave bus
);

    localparam int unsigned AW = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;
    localparam int unsigned CW = $clog2(MEMORY_DEPTH + 1);

    state_e        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic          load_ready_q, load_ready_d;
    logic          load_done_q, load_done_d;
    logic          instr_valid_q, instr_valid_d;
    logic          fault_mis_q, fault_mis_d;
    logic          fault_range_q, fault_range_d;
    // Set when the last response was a fault (or after reset): Instruction shows NOP.
    logic          nop_q, nop_d;

    logic                  serve;
    logic                  misaligned;
    logic                  out_of_range;
    logic [DATA_WIDTH-1:0] offset;
    logic [DATA_WIDTH-1:0] index;
    logic                  ram_we;
    logic                  ram_re;
    logic [DATA_WIDTH-1:0] ram_rdata;

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        ram_we       = 1'b0;

        offset       = bus.Address - BASE_ADDRESS;
        index        = offset >> 2;
        misaligned   = (bus.Address[1:0] != 2'b00);
        out_of_range = (bus.Address < BASE_ADDRESS) || (index >= DATA_WIDTH'(MEMORY_DEPTH));
        serve        = bus.fetch_req && (state_q == RUN);

        // load_start wins over everything, including a word offered in the same cycle.
        if (bus.load_start) begin
            state_d = LOAD;
            count_d = '0;
        end else begin
            unique case (state_q)
                IDLE: ;
                LOAD: begin
                    if (bus.load_valid) begin
                        ram_we  = 1'b1;
                        count_d = count_q + CW'(1);
                        // Leaving on the final slot keeps load_ready low while full.
                        if (bus.load_last || (count_q == CW'(MEMORY_DEPTH - 1))) begin
                            state_d = RUN;
                        end
                    end
                end
                RUN: ;
                default: state_d = IDLE;
            endcase
        end

        load_ready_d  = (state_d == LOAD);
        load_done_d   = (state_d == RUN);
        instr_valid_d = serve;
        fault_mis_d   = serve && misaligned;
        fault_range_d = serve && out_of_range;
        nop_d         = serve ? (misaligned || out_of_range) : nop_q;
        ram_re        = serve && !misaligned && !out_of_range;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            count_q       <= '0;
            load_ready_q  <= 1'b0;
            load_done_q   <= 1'b0;
            instr_valid_q <= 1'b0;
            fault_mis_q   <= 1'b0;
            fault_range_q <= 1'b0;
            nop_q         <= 1'b1;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            load_ready_q  <= load_ready_d;
            load_done_q   <= load_done_d;
            instr_valid_q <= instr_valid_d;
            fault_mis_q   <= fault_mis_d;
            fault_range_q <= fault_range_d;
            nop_q         <= nop_d;
        end
    end

    sync_ram_1r1w #(
        .DEPTH (MEMORY_DEPTH),
        .WIDTH (DATA_WIDTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (count_q[AW-1:0]),
        .wdata_i (bus.load_data),
        .re_i    (ram_re),
        .raddr_i (index[AW-1:0]),
        .rdata_o (ram_rdata)
    );

    assign bus.load_ready       = load_ready_q;
    assign bus.load_done        = load_done_q;
    assign bus.load_count       = count_q;
    assign bus.instr_valid      = instr_valid_q;
    assign bus.fault_misaligned = fault_mis_q;
    assign bus.fault_range      = fault_range_q;
    assign bus.Instruction      = nop_q ? DATA_WIDTH'(MIPS_NOP) : ram_rdata;

endmodule

// File: tb/tb_program_memory_loadable.sv
module tb_program_memory_loadable;

    localparam int unsigned DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0040_0000;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    program_memory_loadable_if #(.MEMORY_DEPTH(DEPTH), .DATA_WIDTH(32)) bus ();

    program_memory_loadable #(
        .MEMORY_DEPTH (DEPTH),
        .DATA_WIDTH   (32),
        .BASE_ADDRESS (BASE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; outputs are checked there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.load_start = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        bus.load_last  = 1'b0;
        bus.fetch_req  = 1'b0;
        bus.Address    = '0;
    endtask

    task automatic load_start_pulse();
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] data, input logic last);
        bus.load_valid = 1'b1;
        bus.load_data  = data;
        bus.load_last  = last;
        tick();
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
    endtask

    task automatic fetch(input string tag, input logic [31:0] addr, input logic [31:0] exp_instr,
                         input logic exp_mis, input logic exp_rng);
        bus.fetch_req = 1'b1;
        bus.Address   = addr;
        tick();
        bus.fetch_req = 1'b0;
        check({tag, ".valid"}, 32'(bus.instr_valid), 32'd1);
        check({tag, ".instr"}, bus.Instruction, exp_instr);
        check({tag, ".mis"}, 32'(bus.fault_misaligned), 32'(exp_mis));
        check({tag, ".rng"}, 32'(bus.fault_range), 32'(exp_rng));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".ready"}, 32'(bus.load_ready), 32'd0);
        check({tag, ".done"}, 32'(bus.load_done), 32'd0);
        check({tag, ".count"}, 32'(bus.load_count), 32'd0);
        check({tag, ".instr"}, bus.Instruction, 32'd0);
        check({tag, ".valid"}, 32'(bus.instr_valid), 32'd0);
        check({tag, ".mis"}, 32'(bus.fault_misaligned), 32'd0);
        check({tag, ".rng"}, 32'(bus.fault_range), 32'd0);
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check_reset_outputs("reset");

        // Fetch in IDLE is ignored.
        bus.fetch_req = 1'b1;
        bus.Address   = BASE;
        tick();
        bus.fetch_req = 1'b0;
        check("idle_fetch.valid", 32'(bus.instr_valid), 32'd0);
        check("idle_fetch.ready", 32'(bus.load_ready), 32'd0);

        // Enter LOAD; fetch there is ignored too.
        load_start_pulse();
        check("load.ready", 32'(bus.load_ready), 32'd1);
        check("load.count0", 32'(bus.load_count), 32'd0);
        bus.fetch_req = 1'b1;
        tick();
        bus.fetch_req = 1'b0;
        check("load_fetch.valid", 32'(bus.instr_valid), 32'd0);

        // Four-word program; a fetch on the final-accept edge is ignored.
        push_word(32'h2008_0005, 1'b0);
        push_word(32'h2009_0003, 1'b0);
        push_word(32'h0109_5020, 1'b0);
        check("prog.count3", 32'(bus.load_count), 32'd3);
        bus.fetch_req = 1'b1;
        bus.Address   = BASE;
        push_word(32'h0810_0000, 1'b1);
        bus.fetch_req = 1'b0;
        check("prog.count4", 32'(bus.load_count), 32'd4);
        check("prog.done", 32'(bus.load_done), 32'd1);
        check("prog.ready", 32'(bus.load_ready), 32'd0);
        check("prog.last_edge_fetch", 32'(bus.instr_valid), 32'd0);

        // Back-to-back fetches.
        fetch("f0", BASE + 32'd0, 32'h2008_0005, 1'b0, 1'b0);
        fetch("f1", BASE + 32'd4, 32'h2009_0003, 1'b0, 1'b0);
        fetch("f2", BASE + 32'd8, 32'h0109_5020, 1'b0, 1'b0);
        fetch("f3", BASE + 32'd12, 32'h0810_0000, 1'b0, 1'b0);
        tick();
        check("hold.valid", 32'(bus.instr_valid), 32'd0);
        check("hold.instr", bus.Instruction, 32'h0810_0000);

        // Fault cases.
        fetch("mis", 32'h0040_0002, 32'd0, 1'b1, 1'b0);
        fetch("below", 32'h003F_FFFC, 32'd0, 1'b0, 1'b1);
        fetch("above", BASE + 32'(4 * DEPTH), 32'd0, 1'b0, 1'b1);
        fetch("both", 32'h003F_FFFE, 32'd0, 1'b1, 1'b1);
        tick();
        check("fault_hold.instr", bus.Instruction, 32'd0);
        check("fault_hold.rng", 32'(bus.fault_range), 32'd0);

        // Reload in RUN with one word.
        load_start_pulse();
        check("reload.ready", 32'(bus.load_ready), 32'd1);
        check("reload.done", 32'(bus.load_done), 32'd0);
        push_word(32'hDEAD_BEEF, 1'b1);
        check("reload.count", 32'(bus.load_count), 32'd1);
        fetch("reload0", BASE, 32'hDEAD_BEEF, 1'b0, 1'b0);
        fetch("reload1", BASE + 32'd4, 32'h2009_0003, 1'b0, 1'b0);

        // load_start with load_valid: counter clears and the word is dropped.
        load_start_pulse();
        push_word(32'h1111_1111, 1'b0);
        bus.load_start = 1'b1;
        push_word(32'h2222_2222, 1'b0);
        bus.load_start = 1'b0;
        check("restart.count", 32'(bus.load_count), 32'd0);
        check("restart.ready", 32'(bus.load_ready), 32'd1);
        push_word(32'h3333_3333, 1'b1);
        fetch("restart0", BASE, 32'h3333_3333, 1'b0, 1'b0);
        fetch("restart1", BASE + 32'd4, 32'h2009_0003, 1'b0, 1'b0);

        // Full load without load_last.
        load_start_pulse();
        for (int i = 0; i < DEPTH - 1; i++) begin
            push_word(32'hA000_0000 + 32'(i), 1'b0);
        end
        check("full63.ready", 32'(bus.load_ready), 32'd1);
        check("full63.done", 32'(bus.load_done), 32'd0);
        push_word(32'hA000_0000 + 32'(DEPTH - 1), 1'b0);
        check("full.ready", 32'(bus.load_ready), 32'd0);
        check("full.done", 32'(bus.load_done), 32'd1);
        check("full.count", 32'(bus.load_count), 32'(DEPTH));
        push_word(32'hFFFF_FFFF, 1'b1);
        check("full.extra_count", 32'(bus.load_count), 32'(DEPTH));
        fetch("full_top", BASE + 32'(4 * (DEPTH - 1)), 32'hA000_0000 + 32'(DEPTH - 1), 1'b0, 1'b0);
        fetch("full0", BASE, 32'hA000_0000, 1'b0, 1'b0);

        // Reset together with a fetch drops the response.
        bus.fetch_req = 1'b1;
        bus.Address   = BASE;
        reset         = 1'b1;
        tick();
        bus.fetch_req = 1'b0;
        reset         = 1'b0;
        check_reset_outputs("rst_fetch");

        // Reset mid-LOAD keeps written words.
        load_start_pulse();
        push_word(32'hB000_0000, 1'b0);
        push_word(32'hB000_0001, 1'b0);
        check("midload.count", 32'(bus.load_count), 32'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_outputs("rst_load");
        load_start_pulse();
        push_word(32'hC000_0000, 1'b1);
        fetch("kept0", BASE, 32'hC000_0000, 1'b0, 1'b0);
        fetch("kept1", BASE + 32'd4, 32'hB000_0001, 1'b0, 1'b0);
        fetch("kept2", BASE + 32'd8, 32'hA000_0002, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
